pio_blink_sequencer: RTL and testbench
======================================

// Module: pio_blink_sequencer
// PURPOSE
//  Avalon-MM master-side sequencer for a single-bit PIO output port (LED/PWM-enable PIO).
//  Sits between the Nios II data master and the PIO s1 slave.
//  Issues timed single-cycle writes that drive an autonomous on/off pattern.
//  Also forwards manual CPU writes to the PIO and arbitrates them against sequencer writes.
// PARAMETERS
//  PRESCALE  50000  clocks per tick (1 ms at 50 MHz); legal range >=2
//  TICK_W    16     width of ON_TICKS/OFF_TICKS registers
// PORTS
//  clk            in   1   system clock
//  reset_n        in   1   reset: asynchronous, active-low
//  s_address      in   2   CPU slave: 0 CTRL, 1 ON_TICKS, 2 OFF_TICKS, 3 MANUAL(wr)/STATUS(rd)
//  s_chipselect   in   1   CPU slave select
//  s_write_n      in   1   CPU slave write strobe, active-low
//  s_writedata    in   32  CPU slave write data
//  s_readdata     out  32  CPU slave read data; combinational, zero read latency
//  m_address      out  2   to PIO address; always 0
//  m_chipselect   out  1   to PIO chipselect
//  m_write_n      out  1   to PIO write_n
//  m_writedata    out  32  to PIO writedata; bit0 = level, bits[31:1] = 0
// BEHAVIOUR
//  Reset values:
//  - All registers = 0; FSM in IDLE; m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0.
//  - s_readdata reflects the reset register values.
//  PIO write:
//  - One clock with m_chipselect=1 and m_write_n=0; always accepted; no waitrequest.
//  - At most one PIO write per clock.
//  Registers:
//  - CTRL[0]: enable.
//  - CTRL[15:8]: repeat count, only with the repeat macro (see CONFIGURATION).
//  - A CTRL write clears STATUS[3].
//  - ON_TICKS/OFF_TICKS: TICK_W bits, zero-extended on read; value 0 is treated as 1.
//  - STATUS = {28'b0, reject, done, level, busy}.
//  FSM states IDLE, ON_WR, ON_WAIT, OFF_WR, OFF_WAIT:
//  - IDLE -> ON_WR: enable==1.
//  - ON_WR (PIO write, data 1) -> ON_WAIT: latch ON_TICKS, clear prescaler and tick counter.
//  - ON_WAIT -> OFF_WR: after ON_TICKS*PRESCALE clocks.
//  - OFF_WR (PIO write, data 0) -> OFF_WAIT: latch OFF_TICKS.
//  - OFF_WAIT -> ON_WR: after OFF_TICKS*PRESCALE clocks.
//  - Resulting high time = ON_TICKS*PRESCALE+1 clocks; low time = OFF_TICKS*PRESCALE+1 clocks.
//  Timing register writes mid-phase: take effect at the next phase entry only.
//  Disable (enable -> 0):
//  - From ON_WAIT, OFF_WAIT or ON_WR: finish the current cycle, then OFF_WR, then IDLE.
//  - From OFF_WR: go to IDLE. The pattern always ends low.
//  - Re-enable while in OFF_WR: continue to OFF_WAIT.
//  Manual write (addr 3):
//  - enable==0 and FSM in IDLE: forwarded to PIO the next clock with writedata[0]; level updated.
//  - enable==0 and FSM not in IDLE: held in a 1-deep pending slot, issued in the first IDLE clock.
//    A newer manual write overwrites the slot.
//  - enable==1: dropped; STATUS[3] reject set (sticky).
//  Arbitration: a sequencer write always wins. A manual write never coincides with a sequencer write.
//  busy = FSM not in IDLE or manual write pending. level = last value written to the PIO.
//  Counters wrap-free: the tick counter compares against the latched value and saturates; no overflow.
// CONFIGURATION
//  PIO_SEQ_REPEAT_EN defined:
//  - CTRL[15:8] = N; N=0 means run forever.
//  - After N completed ON+OFF periods, at the end of OFF_WAIT: enable cleared, FSM to IDLE, STATUS[2] done set.
//  - Writing enable=1 clears done and restarts the count.
//  PIO_SEQ_REPEAT_EN undefined:
//  - CTRL[15:8] ignored and reads 0; runs forever; STATUS[2] reads 0.
// TESTING (PRESCALE=4)
//  1. Reset mid-ON_WAIT -> all m_* at reset values the same cycle; STATUS reads 0; no PIO write after release.
//  2. ON=3, OFF=2, CTRL=1 -> PIO writes 1 then 0; high 13 clocks, low 9 clocks; repeats.
//  3. Running, CTRL=0 during ON_WAIT -> exactly one write of 0 next cycle, then IDLE; busy=0.
//  4. Running, MANUAL=1 -> no PIO write, STATUS=0x9; then CTRL=0 -> bit3 cleared.
//  5. Disable during ON_WAIT, MANUAL=1 the next clock -> OFF write first, then manual write in the first IDLE clock; level=1.
//  6. REPEAT_EN, CTRL=0x0201 -> exactly 2 high pulses; then STATUS=0x4, CTRL[0]=0.

Source files
------------

// File: rtl/pio_blink_sequencer.sv
// ============================================================================
// Module   : pio_blink_sequencer
// Brief    : Avalon-MM sequencer driving a timed on/off pattern into a 1-bit
//            PIO, with arbitrated manual CPU writes. Optional repeat count
//            enabled by defining PIO_SEQ_REPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pio_blink_sequencer #(
  parameter int PRESCALE = 50000,
  parameter int TICK_W   = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  s_address,
  input  logic        s_chipselect,
  input  logic        s_write_n,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata
);

  localparam int                c_PRE_W    = $clog2(PRESCALE);
  localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(PRESCALE - 1);
  localparam logic [TICK_W-1:0] c_TICK_ONE = TICK_W'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ON_WR    = 3'd1,
    S_ON_WAIT  = 3'd2,
    S_OFF_WR   = 3'd3,
    S_OFF_WAIT = 3'd4
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_enable, r_reject, r_level, r_man_pend, r_man_val;
  logic [TICK_W-1:0]   r_on_ticks, r_off_ticks, r_ticks_lat, r_tick_cnt;
  logic [c_PRE_W-1:0]  r_pre_cnt;
  logic                w_cpu_wr, w_wr_ctrl, w_wr_on, w_wr_off, w_wr_man;
  logic                w_tick_last, w_phase_end, w_period_end, w_man_issue, w_busy;
  logic                w_rep_finish, w_done;
  logic [7:0]          w_repeat;
  logic                w_unused;

  assign w_cpu_wr  = s_chipselect & ~s_write_n;
  assign w_wr_ctrl = w_cpu_wr && (s_address == 2'd0);
  assign w_wr_on   = w_cpu_wr && (s_address == 2'd1);
  assign w_wr_off  = w_cpu_wr && (s_address == 2'd2);
  assign w_wr_man  = w_cpu_wr && (s_address == 2'd3);
  assign w_unused  = ^s_writedata;

  // Tick counter saturates on the latched phase length, so it can never wrap.
  assign w_tick_last  = (r_tick_cnt == r_ticks_lat - c_TICK_ONE);
  assign w_phase_end  = w_tick_last && (r_pre_cnt == c_PRE_LAST);
  assign w_period_end = (r_state == S_OFF_WAIT) && r_enable && w_phase_end;
  assign w_man_issue  = (r_state == S_IDLE) && r_man_pend;
  assign w_busy       = (r_state != S_IDLE) || r_man_pend;

`ifdef PIO_SEQ_REPEAT_EN
  logic [7:0] r_repeat, r_rep_cnt;
  logic       r_done, w_rep_last;

  assign w_rep_last   = (r_repeat != 8'd0) && (r_rep_cnt == r_repeat - 8'd1);
  assign w_rep_finish = w_period_end && w_rep_last;
  assign w_repeat     = r_repeat;
  assign w_done       = r_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_repeat  <= 8'd0;
      r_rep_cnt <= 8'd0;
      r_done    <= 1'b0;
    end else if (w_wr_ctrl) begin
      r_repeat <= s_writedata[15:8];
      if (s_writedata[0]) begin
        r_rep_cnt <= 8'd0;
        r_done    <= 1'b0;
      end
    end else if (w_period_end) begin
      if (w_rep_last) begin
        r_rep_cnt <= 8'd0;
        r_done    <= 1'b1;
      end else begin
        r_rep_cnt <= r_rep_cnt + 8'd1;
      end
    end
  end
`else
  assign w_rep_finish = 1'b0;
  assign w_repeat     = 8'd0;
  assign w_done       = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_enable    <= 1'b0;
      r_reject    <= 1'b0;
      r_level     <= 1'b0;
      r_man_pend  <= 1'b0;
      r_man_val   <= 1'b0;
      r_on_ticks  <= '0;
      r_off_ticks <= '0;
      r_ticks_lat <= '0;
      r_tick_cnt  <= '0;
      r_pre_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_wr_on)  r_on_ticks  <= s_writedata[TICK_W-1:0];
      if (w_wr_off) r_off_ticks <= s_writedata[TICK_W-1:0];

      if (w_wr_ctrl)         r_enable <= s_writedata[0];
      else if (w_rep_finish) r_enable <= 1'b0;

      if (w_wr_ctrl)                 r_reject <= 1'b0;
      else if (w_wr_man && r_enable) r_reject <= 1'b1;

      // Newest manual write always overwrites the single pending slot.
      if (w_wr_man && !r_enable) begin
        r_man_pend <= 1'b1;
        r_man_val  <= s_writedata[0];
      end else if (w_man_issue) begin
        r_man_pend <= 1'b0;
      end

      if (m_chipselect) r_level <= m_writedata[0];

      case (r_state)
        S_ON_WR:  r_ticks_lat <= (r_on_ticks == '0)  ? c_TICK_ONE : r_on_ticks;
        S_OFF_WR: r_ticks_lat <= (r_off_ticks == '0) ? c_TICK_ONE : r_off_ticks;
        default:  ;
      endcase

      if (r_state == S_ON_WAIT || r_state == S_OFF_WAIT) begin
        if (r_pre_cnt == c_PRE_LAST) begin
          r_pre_cnt <= '0;
          if (!w_tick_last) r_tick_cnt <= r_tick_cnt + c_TICK_ONE;
        end else begin
          r_pre_cnt <= r_pre_cnt + 1'b1;
        end
      end else begin
        r_pre_cnt  <= '0;
        r_tick_cnt <= '0;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (r_enable) w_state_nxt = S_ON_WR;
      S_ON_WR:    w_state_nxt = r_enable ? S_ON_WAIT : S_OFF_WR;
      S_ON_WAIT:  if (!r_enable || w_phase_end) w_state_nxt = S_OFF_WR;
      S_OFF_WR:   w_state_nxt = r_enable ? S_OFF_WAIT : S_IDLE;
      S_OFF_WAIT: begin
        if (!r_enable)        w_state_nxt = S_OFF_WR;
        else if (w_phase_end) w_state_nxt = w_rep_finish ? S_IDLE : S_ON_WR;
      end
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Manual writes only issue from IDLE, so they never collide with sequencer writes.
  always_comb begin
    m_address    = 2'd0;
    m_chipselect = (r_state == S_ON_WR) || (r_state == S_OFF_WR) || w_man_issue;
    m_write_n    = ~m_chipselect;
    m_writedata  = 32'd0;
    if (r_state == S_ON_WR)  m_writedata[0] = 1'b1;
    else if (w_man_issue)    m_writedata[0] = r_man_val;
  end

  always_comb begin
    s_readdata = 32'd0;
    case (s_address)
      2'd0:    s_readdata = {16'd0, w_repeat, 7'd0, r_enable};
      2'd1:    s_readdata = 32'(r_on_ticks);
      2'd2:    s_readdata = 32'(r_off_ticks);
      default: s_readdata = {28'd0, r_reject, w_done, r_level, w_busy};
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_pio_blink_sequencer.sv
// ============================================================================
// Module   : tb_pio_blink_sequencer
// Brief    : Directed self-checking bench for pio_blink_sequencer, PRESCALE=4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pio_blink_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  s_address = 2'd0;
  logic        s_chipselect = 1'b0;
  logic        s_write_n = 1'b1;
  logic [31:0] s_writedata = 32'd0;
  logic [31:0] s_readdata;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int bad_fmt = 0;

  typedef struct {
    int   c;
    logic d;
  } wr_t;
  wr_t log_q[$];

  pio_blink_sequencer #(.PRESCALE(4), .TICK_W(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_address    (s_address),
    .s_chipselect (s_chipselect),
    .s_write_n    (s_write_n),
    .s_writedata  (s_writedata),
    .s_readdata   (s_readdata),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write_n    (m_write_n),
    .m_writedata  (m_writedata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset_n && m_chipselect && !m_write_n) begin
      log_q.push_back('{c: cyc, d: m_writedata[0]});
      if (m_writedata[31:1] != 31'd0 || m_address != 2'd0) bad_fmt++;
    end
  end

  task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
    s_address = a; s_writedata = d; s_chipselect = 1'b1; s_write_n = 1'b0;
    @(negedge clk);
    s_chipselect = 1'b0; s_write_n = 1'b1;
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
    s_address = a;
    #1;
    d = s_readdata;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    log_q.delete();
  endtask

  task automatic start(input int on_t, input int off_t, input logic [31:0] ctrl, output int t_en);
    cpu_write(2'd1, 32'(on_t));
    cpu_write(2'd2, 32'(off_t));
    cpu_write(2'd0, ctrl);
    t_en = cyc;
  endtask

  task automatic test_reset();
    int t;
    logic [31:0] rd;
    do_reset();
    start(3, 2, 32'd1, t);
    repeat (4) @(negedge clk);
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if (m_chipselect !== 1'b0 || m_write_n !== 1'b1 || m_address !== 2'd0 || m_writedata !== 32'd0) begin
      errors++;
      $display("FAIL reset_m_outputs: cs=%b wn=%b addr=%0d wd=%h, required cs=0 wn=1 addr=0 wd=0",
               m_chipselect, m_write_n, m_address, m_writedata);
    end
    for (int a = 0; a < 4; a++) begin
      cpu_read(2'(a), rd);
      checks++;
      if (rd !== 32'd0) begin
        errors++;
        $display("FAIL reset_read_addr%0d: got %h, required 00000000", a, rd);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    log_q.delete();
    repeat (30) @(negedge clk);
    checks++;
    if (log_q.size() != 0) begin
      errors++;
      $display("FAIL reset_no_write: %0d PIO writes after release, required 0", log_q.size());
    end
  endtask

  task automatic test_regs();
    logic [31:0] rd;
    do_reset();
    cpu_write(2'd1, 32'hABC12345);
    cpu_write(2'd2, 32'h0000FFFF);
    cpu_read(2'd1, rd);
    checks++;
    if (rd !== 32'h00002345) begin
      errors++; $display("FAIL on_ticks_readback: got %h, required 00002345", rd);
    end
    cpu_read(2'd2, rd);
    checks++;
    if (rd !== 32'h0000FFFF) begin
      errors++; $display("FAIL off_ticks_readback: got %h, required 0000ffff", rd);
    end
  endtask

  task automatic test_pattern();
    int t;
    int exp_c[4];
    logic exp_d[4];
    do_reset();
    start(3, 2, 32'd1, t);
    repeat (50) @(negedge clk);
    exp_c = '{t + 1, t + 14, t + 23, t + 36};
    exp_d = '{1'b1, 1'b0, 1'b1, 1'b0};
    checks++;
    if (log_q.size() < 4) begin
      errors++; $display("FAIL pattern_count: %0d writes, required at least 4", log_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (log_q[i].c != exp_c[i] || log_q[i].d !== exp_d[i]) begin
          errors++;
          $display("FAIL pattern_write%0d: cycle %0d data %b, required cycle %0d data %b",
                   i, log_q[i].c - t, log_q[i].d, exp_c[i] - t, exp_d[i]);
        end
      end
    end
    checks++;
    if (bad_fmt != 0) begin
      errors++; $display("FAIL write_format: %0d writes with nonzero addr/upper data, required 0", bad_fmt);
    end
  endtask

  task automatic test_zero_ticks();
    int t;
    do_reset();
    start(0, 0, 32'd1, t);
    repeat (20) @(negedge clk);
    checks++;
    if (log_q.size() < 3 || log_q[1].c - log_q[0].c != 5 || log_q[2].c - log_q[1].c != 5) begin
      errors++;
      $display("FAIL zero_ticks_timing: %0d writes, first gaps %0d/%0d, required 5/5", log_q.size(),
               (log_q.size() > 1) ? log_q[1].c - log_q[0].c : -1,
               (log_q.size() > 2) ? log_q[2].c - log_q[1].c : -1);
    end
  endtask

  task automatic test_disable();
    int t, td;
    logic [31:0] rd;
    do_reset();
    start(3, 2, 32'd1, t);
    repeat (3) @(negedge clk);
    log_q.delete();
    cpu_write(2'd0, 32'd0);
    td = cyc;
    repeat (20) @(negedge clk);
    checks++;
    if (log_q.size() != 1 || log_q[0].d !== 1'b0 || log_q[0].c != td + 1) begin
      errors++;
      $display("FAIL disable_off_write: %0d writes, first data %b at +%0d, required 1 write of 0 at +1",
               log_q.size(), (log_q.size() > 0) ? log_q[0].d : 1'bx,
               (log_q.size() > 0) ? log_q[0].c - td : -1);
    end
    cpu_read(2'd3, rd);
    checks++;
    if (rd !== 32'd0) begin
      errors++; $display("FAIL disable_status: got %h, required 00000000", rd);
    end
  endtask

  task automatic test_reject();
    int t;
    logic [31:0] rd;
    do_reset();
    start(1, 10, 32'd1, t);
    repeat (9) @(negedge clk);
    cpu_write(2'd3, 32'd1);
    cpu_read(2'd3, rd);
    checks++;
    if (rd !== 32'h9) begin
      errors++; $display("FAIL reject_status: got %h, required 00000009", rd);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (log_q.size() != 2) begin
      errors++; $display("FAIL reject_no_write: %0d PIO writes, required 2", log_q.size());
    end
    cpu_write(2'd0, 32'd0);
    cpu_read(2'd3, rd);
    checks++;
    if (rd[3] !== 1'b0) begin
      errors++; $display("FAIL reject_clear: status %h, required bit3 clear", rd);
    end
    repeat (5) @(negedge clk);
    cpu_read(2'd3, rd);
    checks++;
    if (rd !== 32'd0) begin
      errors++; $display("FAIL reject_final_status: got %h, required 00000000", rd);
    end
  endtask

  task automatic test_manual_pending();
    int t, tm;
    logic [31:0] rd;
    do_reset();
    start(3, 2, 32'd1, t);
    repeat (3) @(negedge clk);
    log_q.delete();
    cpu_write(2'd0, 32'd0);
    cpu_write(2'd3, 32'd1);
    tm = cyc;
    repeat (20) @(negedge clk);
    checks++;
    if (log_q.size() != 2 || log_q[0].d !== 1'b0 || log_q[0].c != tm ||
        log_q[1].d !== 1'b1 || log_q[1].c != tm + 1) begin
      errors++;
      $display("FAIL manual_order: %0d writes, got %b@+%0d %b@+%0d, required 0@+0 1@+1", log_q.size(),
               (log_q.size() > 0) ? log_q[0].d : 1'bx, (log_q.size() > 0) ? log_q[0].c - tm : -1,
               (log_q.size() > 1) ? log_q[1].d : 1'bx, (log_q.size() > 1) ? log_q[1].c - tm : -1);
    end
    cpu_read(2'd3, rd);
    checks++;
    if (rd !== 32'h2) begin
      errors++; $display("FAIL manual_level: status %h, required 00000002", rd);
    end
    log_q.delete();
    cpu_write(2'd3, 32'd0);
    repeat (3) @(negedge clk);
    checks++;
    if (log_q.size() != 1 || log_q[0].d !== 1'b0) begin
      errors++; $display("FAIL manual_idle_forward: %0d writes, required 1 write of 0", log_q.size());
    end
  endtask

  task automatic test_repeat();
    int t, highs;
    logic [31:0] rd;
    do_reset();
    start(1, 1, 32'h0000_0201, t);
    repeat (60) @(negedge clk);
    highs = 0;
    foreach (log_q[i]) if (log_q[i].d === 1'b1) highs++;
`ifdef PIO_SEQ_REPEAT_EN
    checks++;
    if (highs != 2 || log_q.size() != 4) begin
      errors++; $display("FAIL repeat_pulses: %0d high of %0d writes, required 2 of 4", highs, log_q.size());
    end
    cpu_read(2'd3, rd);
    checks++;
    if (rd !== 32'h4) begin
      errors++; $display("FAIL repeat_status: got %h, required 00000004", rd);
    end
    cpu_read(2'd0, rd);
    checks++;
    if (rd !== 32'h0000_0200) begin
      errors++; $display("FAIL repeat_ctrl: got %h, required 00000200", rd);
    end
`else
    checks++;
    if (highs < 5) begin
      errors++; $display("FAIL repeat_ignored_pulses: %0d high writes, required at least 5", highs);
    end
    cpu_read(2'd0, rd);
    checks++;
    if (rd !== 32'h1) begin
      errors++; $display("FAIL repeat_ignored_ctrl: got %h, required 00000001", rd);
    end
    cpu_read(2'd3, rd);
    checks++;
    if (rd[2] !== 1'b0 || rd[0] !== 1'b1) begin
      errors++; $display("FAIL repeat_ignored_status: got %h, required bit2=0 bit0=1", rd);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_regs();
    test_pattern();
    test_zero_ticks();
    test_disable();
    test_reject();
    test_manual_pending();
    test_repeat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
